// File: rtl/ikaopll_acc_mixer_pkg.sv
// Shared definitions for the OPLL weighted accumulator mixer: width derivation,
// a clog2 helper and the FSM state encoding.
package ikaopll_acc_mixer_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } mix_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int prod_width(input int in_w, input int vol_w);
    return in_w + vol_w;
  endfunction

  // 64 slots of headroom per frame times the number of frames per word.
  function automatic int acc_width(input int in_w, input int vol_w, input int decim);
    return prod_width(in_w, vol_w) + clog2(64 * decim);
  endfunction

  function automatic int cnt_width(input int decim);
    return (decim > 1) ? clog2(decim) : 1;
  endfunction

endpackage

// File: rtl/ikaopll_acc_mixer_sat.sv
// Combinational arithmetic right shift followed by clamp-or-wrap down to OUT_W.
module ikaopll_mix_sat #(
  parameter int IN_W     = 20,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 0,
  parameter int SATURATE = 1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam int W = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;
  logic signed [W-1:0]    ext;
  logic                   over_hi;
  logic                   over_lo;

  always_comb begin
    shifted = din >>> SHIFT;
    ext     = W'(shifted);
    over_hi = (ext > MAX_V);
    over_lo = (ext < MIN_V);
    if (SATURATE != 0) begin
      if (over_hi)      dout = MAX_V[OUT_W-1:0];
      else if (over_lo) dout = MIN_V[OUT_W-1:0];
      else              dout = ext[OUT_W-1:0];
      clip = over_hi | over_lo;
    end else begin
      dout = ext[OUT_W-1:0];
      clip = 1'b0;
    end
  end

endmodule

// File: rtl/ikaopll_acc_mixer.sv
// N-source weighted slot-sample accumulator: multiply by group volume (S1),
// accumulate over DECIM frames (S2), emit one strobed, saturated PCM word.
module ikaopll_acc_mixer
  import ikaopll_acc_mixer_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int IN_W     = 9,
  parameter int VOL_W    = 5,
  parameter int OUT_W    = 16,
  parameter int DECIM    = 1,
  parameter int SHIFT    = 0,
  parameter int SATURATE = 1
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_RST,
  input  logic                     i_phi1_NCEN_n,
  input  logic                     i_DAC_EN,
  input  logic                     i_CYCLE_00,
  input  logic [NUM_SRC-1:0]       i_SRC_SEL,
  input  logic [IN_W-1:0]          i_SAMPLE,
  input  logic [NUM_SRC*VOL_W-1:0] i_VOL,
  output logic                     o_STRB,
  output logic [OUT_W-1:0]         o_SAMPLE,
  output logic                     o_CLIP,
  output mix_state_t               dbg_state
);

  localparam int PROD_W = prod_width(IN_W, VOL_W);
  localparam int ACC_W  = acc_width(IN_W, VOL_W, DECIM);
  localparam int CNT_W  = cnt_width(DECIM);

  // ---------------- S1: volume select and product ----------------
  logic                     en;
  logic signed [VOL_W-1:0]  vol_sel;
  logic                     sel_any;
  logic signed [PROD_W-1:0] smp_x;
  logic signed [PROD_W-1:0] vol_x;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] s1_prod;
  logic                     s1_mark;

  assign en = ~i_phi1_NCEN_n;

  // Scanning downward makes the lowest set select bit win.
  always_comb begin
    vol_sel = '0;
    sel_any = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (i_SRC_SEL[k]) begin
        vol_sel = i_VOL[k*VOL_W +: VOL_W];
        sel_any = 1'b1;
      end
    end
  end

  always_comb begin
    smp_x  = {{VOL_W{i_SAMPLE[IN_W-1]}}, i_SAMPLE};
    vol_x  = {{IN_W{vol_sel[VOL_W-1]}}, vol_sel};
    prod_c = smp_x * vol_x;
  end

  // Invalid cycles register a zero product so S2 can add unconditionally.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      s1_prod <= '0;
      s1_mark <= 1'b0;
    end else begin
      s1_prod <= (en & i_DAC_EN & sel_any) ? prod_c : '0;
      s1_mark <= en & i_CYCLE_00;
    end
  end

  // ---------------- S2: FSM and accumulator ----------------
  mix_state_t               state_q;
  mix_state_t               state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [CNT_W-1:0]         cnt_q;
  logic                     cnt_last;
  logic                     acc_load;
  logic                     acc_add;
  logic                     cnt_inc;
  logic                     cnt_clr;
  logic                     emit;
  logic signed [OUT_W-1:0]  sat_word;
  logic                     sat_clip;

  assign prod_ext  = {{(ACC_W-PROD_W){s1_prod[PROD_W-1]}}, s1_prod};
  assign cnt_last  = (cnt_q == CNT_W'(DECIM - 1));
  assign dbg_state = state_q;

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) state_q <= ST_PRIME;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PRIME: if (s1_mark) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_PRIME;
    endcase
  end

  // The marker-cycle product always opens a new frame; it is never split.
  always_comb begin
    acc_load = 1'b0;
    acc_add  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    emit     = 1'b0;
    case (state_q)
      ST_PRIME: begin
        if (s1_mark) begin
          acc_load = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        if (s1_mark && cnt_last) begin
          emit     = 1'b1;
          acc_load = 1'b1;
          cnt_clr  = 1'b1;
        end else if (s1_mark) begin
          acc_add = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          acc_add = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ikaopll_mix_sat #(
    .IN_W     (ACC_W),
    .OUT_W    (OUT_W),
    .SHIFT    (SHIFT),
    .SATURATE (SATURATE)
  ) u_sat (
    .din  (acc_q),
    .dout (sat_word),
    .clip (sat_clip)
  );

  // o_STRB is a single-cycle pulse; o_SAMPLE and o_CLIP hold until the next one.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      o_STRB   <= 1'b0;
      o_SAMPLE <= '0;
      o_CLIP   <= 1'b0;
    end else begin
      if (acc_load)     acc_q <= prod_ext;
      else if (acc_add) acc_q <= acc_q + prod_ext;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      o_STRB <= emit;
      if (emit) begin
        o_SAMPLE <= sat_word;
        o_CLIP   <= sat_clip;
      end
    end
  end

endmodule

// File: tb/tb_ikaopll_acc_mixer.sv
// Directed bench for ikaopll_acc_mixer: default, 8-bit saturating, 8-bit wrapping
// and DECIM=4 instances share one stimulus stream.
module tb_ikaopll_acc_mixer;
  import ikaopll_acc_mixer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       ncen_n;
  logic       dac_en;
  logic       cyc00;
  logic [1:0] src_sel;
  logic [8:0] sample;
  logic [9:0] vol;

  logic        strb_def, clip_def;
  logic [15:0] smp_def;
  mix_state_t  st_def;
  logic        strb_s8, clip_s8;
  logic [7:0]  smp_s8;
  mix_state_t  st_s8;
  logic        strb_w8, clip_w8;
  logic [7:0]  smp_w8;
  mix_state_t  st_w8;
  logic        strb_d4, clip_d4;
  logic [15:0] smp_d4;
  mix_state_t  st_d4;

  ikaopll_acc_mixer u_def (
    .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen_n), .i_DAC_EN(dac_en),
    .i_CYCLE_00(cyc00), .i_SRC_SEL(src_sel), .i_SAMPLE(sample), .i_VOL(vol),
    .o_STRB(strb_def), .o_SAMPLE(smp_def), .o_CLIP(clip_def), .dbg_state(st_def));

  ikaopll_acc_mixer #(.OUT_W(8)) u_s8 (
    .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen_n), .i_DAC_EN(dac_en),
    .i_CYCLE_00(cyc00), .i_SRC_SEL(src_sel), .i_SAMPLE(sample), .i_VOL(vol),
    .o_STRB(strb_s8), .o_SAMPLE(smp_s8), .o_CLIP(clip_s8), .dbg_state(st_s8));

  ikaopll_acc_mixer #(.OUT_W(8), .SATURATE(0)) u_w8 (
    .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen_n), .i_DAC_EN(dac_en),
    .i_CYCLE_00(cyc00), .i_SRC_SEL(src_sel), .i_SAMPLE(sample), .i_VOL(vol),
    .o_STRB(strb_w8), .o_SAMPLE(smp_w8), .o_CLIP(clip_w8), .dbg_state(st_w8));

  ikaopll_acc_mixer #(.DECIM(4)) u_d4 (
    .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen_n), .i_DAC_EN(dac_en),
    .i_CYCLE_00(cyc00), .i_SRC_SEL(src_sel), .i_SAMPLE(sample), .i_VOL(vol),
    .o_STRB(strb_d4), .o_SAMPLE(smp_d4), .o_CLIP(clip_d4), .dbg_state(st_d4));

  // ---------------- scoreboard counters ----------------
  int total;
  int passes;
  int fails;
  int n_def, n_s8, n_w8, n_d4;

  task automatic check(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic en_n, input logic dac, input logic cyc,
                       input logic [1:0] sel, input int smp);
    ncen_n  = en_n;
    dac_en  = dac;
    cyc00   = cyc;
    src_sel = sel;
    sample  = smp[8:0];
    @(posedge clk);
    #1;
    if (strb_def) n_def = n_def + 1;
    if (strb_s8)  n_s8  = n_s8 + 1;
    if (strb_w8)  n_w8  = n_w8 + 1;
    if (strb_d4)  n_d4  = n_d4 + 1;
  endtask

  task automatic set_vol(input int v0, input int v1);
    vol = {v1[4:0], v0[4:0]};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 2'b00, 0);
    rst = 1'b0;
    n_def = 0; n_s8 = 0; n_w8 = 0; n_d4 = 0;
  endtask

  // Marker sample first, then n-1 body cycles; disabled body cycles also raise CYCLE_00.
  task automatic frame(input int n, input int s_mark, input logic [1:0] sel_mark,
                       input int s_body, input logic [1:0] sel_body, input logic en_n_body);
    cycle(1'b0, 1'b1, 1'b1, sel_mark, s_mark);
    for (int i = 1; i < n; i++) cycle(en_n_body, 1'b1, en_n_body, sel_body, s_body);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total = 0; passes = 0; fails = 0;
    rst = 1'b1; ncen_n = 1'b1; dac_en = 1'b0; cyc00 = 1'b0;
    src_sel = 2'b00; sample = '0; vol = '0;

    // Reset state
    do_reset();
    check("rst_sample", int'(smp_def), 0);
    check("rst_strb", int'(strb_def), 0);
    check("rst_clip", int'(clip_def), 0);
    check("rst_state", int'(st_def), int'(ST_PRIME));

    // 1: 18 x (+10 * +4) per frame, first marker only primes
    set_vol(4, 0);
    frame(18, 10, 2'b01, 10, 2'b01, 1'b0);
    check("t1_no_first_strb", n_def, 0);
    check("t1_state_run", int'(st_def), int'(ST_RUN));
    frame(18, 10, 2'b01, 10, 2'b01, 1'b0);
    frame(18, 10, 2'b01, 10, 2'b01, 1'b0);
    check("t1_strb_count", n_def, 2);
    check("t1_sample", int'($signed(smp_def)), 720);
    check("t1_clip", int'(clip_def), 0);

    // 2: mixed groups, 9 x (+100 * +3) + 9 x (-50 * -2)
    do_reset();
    set_vol(3, -2);
    for (int f = 0; f < 3; f++) begin
      frame(9, 100, 2'b01, 100, 2'b01, 1'b0);
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 2'b10, -50);
    end
    check("t2_strb_count", n_def, 2);
    check("t2_sample", int'($signed(smp_def)), 3600);

    // 3: saturation, 18 x (+255 * +15) = 68850
    do_reset();
    set_vol(15, 0);
    for (int f = 0; f < 3; f++) frame(18, 255, 2'b01, 255, 2'b01, 1'b0);
    check("t3_s8_count", n_s8, 2);
    check("t3_s8_pos", int'($signed(smp_s8)), 127);
    check("t3_s8_pos_clip", int'(clip_s8), 1);
    check("t3_w8_pos", int'($signed(smp_w8)), -14);
    check("t3_w8_pos_clip", int'(clip_w8), 0);
    check("t3_def_pos", int'($signed(smp_def)), 32767);
    check("t3_def_pos_clip", int'(clip_def), 1);

    // 3b: 18 x (-256 * +15) = -69120
    do_reset();
    for (int f = 0; f < 3; f++) frame(18, -256, 2'b01, -256, 2'b01, 1'b0);
    check("t3_s8_neg", int'($signed(smp_s8)), -128);
    check("t3_s8_neg_clip", int'(clip_s8), 1);
    check("t3_w8_neg", int'($signed(smp_w8)), 0);
    check("t3_w8_neg_clip", int'(clip_w8), 0);
    check("t3_def_neg", int'($signed(smp_def)), -32768);

    // 4: DECIM=4, +1 * +1, word = 4 * 18 = 72
    do_reset();
    set_vol(1, 0);
    for (int f = 0; f < 4; f++) frame(18, 1, 2'b01, 1, 2'b01, 1'b0);
    check("t4_none_before_m5", n_d4, 0);
    cycle(1'b0, 1'b1, 1'b1, 2'b01, 1);
    check("t4_lat_edge1", int'(strb_d4), 0);
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 1);
    check("t4_lat_edge2", int'(strb_d4), 1);
    check("t4_sample", int'($signed(smp_d4)), 72);
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 1);
    check("t4_strb_width", int'(strb_d4), 0);
    check("t4_one_strobe", n_d4, 1);
    for (int i = 3; i < 18; i++) cycle(1'b0, 1'b1, 1'b0, 2'b01, 1);
    for (int f = 0; f < 3; f++) frame(18, 1, 2'b01, 1, 2'b01, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 2'b01, 1);
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 1);
    check("t4_strb_count", n_d4, 2);
    check("t4_sample2", int'($signed(smp_d4)), 72);

    // 5a: marker-cycle sample belongs to the word it opens
    do_reset();
    set_vol(1, 0);
    frame(18, 100, 2'b01, 1, 2'b01, 1'b0);
    frame(18, 50, 2'b01, 1, 2'b01, 1'b0);
    check("t5_mark_count", n_def, 1);
    check("t5_mark_word1", int'($signed(smp_def)), 117);
    cycle(1'b0, 1'b1, 1'b1, 2'b01, 7);
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 1);
    check("t5_mark_word2", int'($signed(smp_def)), 67);

    // 5b: SEL=11 picks VOL0 (+2), not VOL1 (-3)
    do_reset();
    set_vol(2, -3);
    for (int f = 0; f < 3; f++) frame(18, 5, 2'b11, 5, 2'b11, 1'b0);
    check("t5_sel11", int'($signed(smp_def)), 180);

    // 5c: SEL=00 contributes zero
    do_reset();
    set_vol(1, 0);
    for (int f = 0; f < 3; f++) frame(18, 3, 2'b01, 100, 2'b00, 1'b0);
    check("t5_sel00", int'($signed(smp_def)), 3);

    // 5d: disabled cycles ignore DAC_EN and CYCLE_00
    do_reset();
    for (int f = 0; f < 3; f++) frame(18, 4, 2'b01, 100, 2'b01, 1'b1);
    check("t5_ncen_count", n_def, 2);
    check("t5_ncen", int'($signed(smp_def)), 4);

    // 6: reset mid-frame
    do_reset();
    set_vol(4, 0);
    frame(18, 10, 2'b01, 10, 2'b01, 1'b0);
    frame(18, 10, 2'b01, 10, 2'b01, 1'b0);
    frame(9, 10, 2'b01, 10, 2'b01, 1'b0);
    check("t6_pre_sample", int'($signed(smp_def)), 720);
    check("t6_pre_s8_clip", int'(clip_s8), 1);
    rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 10);
    check("t6_rst_sample", int'(smp_def), 0);
    check("t6_rst_strb", int'(strb_def), 0);
    check("t6_rst_s8_clip", int'(clip_s8), 0);
    check("t6_rst_state", int'(st_def), int'(ST_PRIME));
    rst = 1'b0;
    n_def = 0;
    frame(18, 5, 2'b01, 5, 2'b01, 1'b0);
    check("t6_no_first_strb", n_def, 0);
    frame(18, 5, 2'b01, 5, 2'b01, 1'b0);
    check("t6_strb_count", n_def, 1);
    check("t6_sample", int'($signed(smp_def)), 360);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
